sha3_axil_regs: RTL and testbench
=================================

# sha3_axil_regs

AXI4-Lite slave register file that is the responder end of the host control path into the SHA3 IP. It accepts single-beat writes and reads from the master, holds NUM_REGS 32-bit read/write registers, and exposes them plus per-register write pulses to the SHA3 datapath. It sits between the AXI interconnect and the SHA3 core inside the IP top level.

## Interface
Parameters:
- DATA_W, 32, AXI data width; only 32 supported.
- ADDR_W, 4, AXI address width; register index is addr[ADDR_W-1:2].
- NUM_REGS, 4, number of registers; must equal 2**(ADDR_W-2).

Ports:
- S_AXI_ACLK  in  1  sole clock; all logic rising-edge.
- S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
- S_AXI_AWADDR  in  ADDR_W  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake.
- S_AXI_ARADDR  in  ADDR_W  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake.
- reg_o  out  NUM_REGS*32  register contents, reg n at [32n+31:32n].
- reg_wr_o  out  NUM_REGS  one-cycle pulse, bit n set cycle after reg n written.

## Operation
- Write side: flags aw_held, w_held plus captured addr/data/strb. AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID (combinational from registers).
- AW and W accepted independently, either order, any gap. Commit edge: first edge where address and data are both available (held or handshaking that cycle). At commit: bytes with WSTRB=1 updated, others kept; flags cleared; BVALID set; reg_wr_o[idx] set for one cycle.
- BVALID held until BREADY; while BVALID high, no new AW/W accepted (one outstanding write).
- Read side: ARREADY = !RVALID. On AR handshake, RDATA <= reg[idx] and RVALID set next edge; RDATA stable while RVALID && !RREADY. One outstanding read.
- Address low bits [1:0] ignored; all indices valid, no SLVERR/DECERR.
- Same-cycle AR accept and write commit to same register: read returns pre-write value.
- Read and write channels fully independent; concurrent activity allowed.

## Timing
- Reset (async, ARESETN low): all registers 0, reg_o 0, reg_wr_o 0, BVALID 0, RVALID 0, RDATA 0, held flags 0; readies go high from the combinational rule once reset releases (AWREADY/WREADY/ARREADY = 1 during reset also acceptable to bench only after deassert; bench must not drive VALID during reset).
- AW+W same cycle C: register and reg_o update at end of C, BVALID and reg_wr_o high in C+1.
- Read: AR handshake in C, RVALID/RDATA in C+1; back-to-back reads every 2 cycles with RREADY tied high.
- Reset mid-transaction: held address/data discarded, pending BVALID/RVALID dropped, no register update.

## Structure
- Package sha3_axil_pkg: RESP_OKAY = 2'b00, DATA_W, register index localparams (REG_DATA_IN=0, REG_CTRL=1, REG_AUX0=2, REG_AUX1=3), function apply_wstrb(old, data, strb) returning merged word.
- Single module; no sub-module needed.

## Test plan
- Reset -> all reg_o 0; read 0x0..0xC returns 0x00000000, RRESP 0.
- Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, read back -> 0x1..0x4, BRESP 0; reg_wr_o bits 0..3 pulse once each.
- Reg1 = 0x00000002; write 0xAABBCCDD with WSTRB 4'b0010 -> reads 0x0000CC02.
- W valid 3 cycles before AW to 0x8, data 0x55 -> WREADY drops after handshake, commit on AW handshake, BVALID next cycle, reg2 = 0x55.
- BREADY low 5 cycles after a write -> BVALID held, AWREADY/WREADY low, second write accepted only after B handshake, both values correct.
- ARESETN asserted with AW held and W pending -> no update, BVALID 0, registers 0 after reset.

Source files
------------

// File: rtl/sha3_axil_pkg.sv
// Shared constants and helpers for the SHA3 AXI4-Lite control register block.
// Register indices name the roles the SHA3 datapath assigns to each 32-bit slot.
package sha3_axil_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int REG_DATA_IN = 0;
  localparam int REG_CTRL    = 1;
  localparam int REG_AUX0    = 2;
  localparam int REG_AUX1    = 3;

  // Bytes whose strobe is set take the new data; all other bytes keep the old value.
  function automatic logic [DATA_W-1:0] apply_wstrb(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sha3_axil_regs.sv
// AXI4-Lite slave holding NUM_REGS read/write registers for the SHA3 core.
// One outstanding write and one outstanding read; AW and W may arrive in any order.
module sha3_axil_regs #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 4
) (
  input  logic                       S_AXI_ACLK,
  input  logic                       S_AXI_ARESETN,
  input  logic [ADDR_W-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                 S_AXI_AWPROT,
  input  logic                       S_AXI_AWVALID,
  output logic                       S_AXI_AWREADY,
  input  logic [DATA_W-1:0]          S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]        S_AXI_WSTRB,
  input  logic                       S_AXI_WVALID,
  output logic                       S_AXI_WREADY,
  output logic [1:0]                 S_AXI_BRESP,
  output logic                       S_AXI_BVALID,
  input  logic                       S_AXI_BREADY,
  input  logic [ADDR_W-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                 S_AXI_ARPROT,
  input  logic                       S_AXI_ARVALID,
  output logic                       S_AXI_ARREADY,
  output logic [DATA_W-1:0]          S_AXI_RDATA,
  output logic [1:0]                 S_AXI_RRESP,
  output logic                       S_AXI_RVALID,
  input  logic                       S_AXI_RREADY,
  output logic [NUM_REGS*DATA_W-1:0] reg_o,
  output logic [NUM_REGS-1:0]        reg_wr_o
);
  import sha3_axil_pkg::*;

  localparam int IDX_W = ADDR_W - 2;
  localparam int SW    = DATA_W / 8;

  logic              aw_held_q, aw_held_d;
  logic [IDX_W-1:0]  aw_idx_q,  aw_idx_d;
  logic              w_held_q,  w_held_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic [SW-1:0]     wstrb_q,   wstrb_d;
  logic              bvalid_q,  bvalid_d;
  logic [NUM_REGS-1:0] reg_wr_q, reg_wr_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              rvalid_q,  rvalid_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;

  logic              aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0]  aw_idx_in, ar_idx_in, cm_idx;
  logic [DATA_W-1:0] cm_data;
  logic [SW-1:0]     cm_strb;
  logic              unused_inputs;

  assign S_AXI_AWREADY = !aw_held_q && !bvalid_q;
  assign S_AXI_WREADY  = !w_held_q && !bvalid_q;
  assign S_AXI_ARREADY = !rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign reg_wr_o      = reg_wr_q;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // Byte-offset bits and protection attributes carry no meaning for this block.
  assign aw_idx_in = S_AXI_AWADDR[ADDR_W-1:2];
  assign ar_idx_in = S_AXI_ARADDR[ADDR_W-1:2];
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // A write commits on the first edge where both halves are available, held or arriving.
  assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign cm_idx  = aw_held_q ? aw_idx_q : aw_idx_in;
  assign cm_data = w_held_q ? wdata_q : S_AXI_WDATA;
  assign cm_strb = w_held_q ? wstrb_q : S_AXI_WSTRB;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves a value unassigned and infers a latch.
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    reg_wr_d  = '0;
    regs_d    = regs_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = aw_idx_in;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = S_AXI_WDATA;
      wstrb_d  = S_AXI_WSTRB;
    end

    if (commit) begin
      regs_d[cm_idx]   = apply_wstrb(regs_q[cm_idx], cm_data, cm_strb);
      reg_wr_d[cm_idx] = 1'b1;
      aw_held_d        = 1'b0;
      w_held_d         = 1'b0;
      bvalid_d         = 1'b1;
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    // Reads sample the current register, so a same-edge write is not yet visible.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = regs_q[ar_idx_in];
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      reg_wr_q  <= '0;
      // NOTE: the register array is reset because the host and SHA3 core rely on it reading zero.
      regs_q    <= '{default: '0};
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      reg_wr_q  <= reg_wr_d;
      regs_q    <= regs_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_sha3_axil_regs.sv
// Self-checking bench for sha3_axil_regs: directed scenarios plus randomized traffic
// compared against a word-array model of the register file.
module tb_sha3_axil_regs;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   s_awaddr = '0, s_araddr = '0;
  logic         s_awvalid = 1'b0, s_wvalid = 1'b0, s_arvalid = 1'b0;
  logic         s_bready = 1'b1, s_rready = 1'b1;
  logic [31:0]  s_wdata = '0;
  logic [3:0]   s_wstrb = '0;
  logic         s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]   s_bresp, s_rresp;
  logic [31:0]  s_rdata;
  logic [127:0] s_reg_o;
  logic [3:0]   s_reg_wr;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [4];

  always #5 clk = ~clk;

  sha3_axil_regs #(.DATA_W(32), .ADDR_W(4), .NUM_REGS(4)) dut (
    .S_AXI_ACLK(clk),        .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(s_awaddr), .S_AXI_AWPROT(3'b000),
    .S_AXI_AWVALID(s_awvalid), .S_AXI_AWREADY(s_awready),
    .S_AXI_WDATA(s_wdata),   .S_AXI_WSTRB(s_wstrb),
    .S_AXI_WVALID(s_wvalid), .S_AXI_WREADY(s_wready),
    .S_AXI_BRESP(s_bresp),   .S_AXI_BVALID(s_bvalid), .S_AXI_BREADY(s_bready),
    .S_AXI_ARADDR(s_araddr), .S_AXI_ARPROT(3'b000),
    .S_AXI_ARVALID(s_arvalid), .S_AXI_ARREADY(s_arready),
    .S_AXI_RDATA(s_rdata),   .S_AXI_RRESP(s_rresp),
    .S_AXI_RVALID(s_rvalid), .S_AXI_RREADY(s_rready),
    .reg_o(s_reg_o),         .reg_wr_o(s_reg_wr)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_flat();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  // Byte-lane merge expressed as a mask over the whole word.
  task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    model[addr[3:2]] = (model[addr[3:2]] & ~mask) | (data & mask);
  endtask

  // Starts and ends at a falling edge; hold_b stalls BREADY while junk AW/W are offered.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int hold_b);
    int cyc = 0;
    bit aw_pend = 1'b1, w_pend = 1'b1, aw_fire, w_fire;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    while ((aw_pend || w_pend) && cyc < 100) begin
      check("early_bvalid", s_bvalid, 1'b0);
      if (!w_pend) check("wready_while_held", s_wready, 1'b0);
      if (!aw_pend) check("awready_while_held", s_awready, 1'b0);
      s_awvalid = aw_pend && (cyc >= aw_dly);
      s_wvalid  = w_pend && (cyc >= w_dly);
      aw_fire = s_awvalid && s_awready;
      w_fire  = s_wvalid && s_wready;
      @(negedge clk);
      cyc++;
      if (aw_fire) aw_pend = 1'b0;
      if (w_fire)  w_pend  = 1'b0;
      s_awvalid = 1'b0; s_wvalid = 1'b0;
    end
    check("wr_timeout", aw_pend || w_pend, 1'b0);
    model_write(addr, data, strb);
    check("bvalid", s_bvalid, 1'b1);
    check("bresp", s_bresp, 2'b00);
    check("reg_wr_pulse", s_reg_wr, 4'b0001 << addr[3:2]);
    check("reg_o_after_wr", s_reg_o, model_flat());
    if (hold_b > 0) begin
      s_bready = 1'b0;
      for (int h = 0; h < hold_b; h++) begin
        s_awaddr = 4'($urandom); s_wdata = ~data; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        @(negedge clk);
        check("bvalid_held", s_bvalid, 1'b1);
        check("awready_bhold", s_awready, 1'b0);
        check("wready_bhold", s_wready, 1'b0);
      end
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      s_bready = 1'b1;
    end
    @(negedge clk);
    check("bvalid_clear", s_bvalid, 1'b0);
    check("reg_wr_clear", s_reg_wr, 4'b0000);
    check("reg_o_stable", s_reg_o, model_flat());
  endtask

  task automatic axi_read(input logic [3:0] addr, input int stall);
    int cyc = 0;
    bit fired = 1'b0;
    logic [31:0] exp;
    exp = model[addr[3:2]];
    s_araddr = addr;
    s_arvalid = 1'b1;
    while (!fired && cyc < 100) begin
      fired = s_arready;
      @(negedge clk);
      cyc++;
    end
    s_arvalid = 1'b0;
    check("rd_timeout", fired, 1'b1);
    check("rvalid", s_rvalid, 1'b1);
    check("rdata", s_rdata, exp);
    check("rresp", s_rresp, 2'b00);
    if (stall > 0) begin
      s_rready = 1'b0;
      repeat (stall) begin
        @(negedge clk);
        check("rvalid_stall", s_rvalid, 1'b1);
        check("rdata_stable", s_rdata, exp);
        check("arready_stall", s_arready, 1'b0);
      end
      s_rready = 1'b1;
    end
    @(negedge clk);
    check("rvalid_clear", s_rvalid, 1'b0);
    check("arready_back", s_arready, 1'b1);
  endtask

  initial begin
    logic [31:0] old_val;
    for (int i = 0; i < 4; i++) model[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_reg_o", s_reg_o, '0);
    check("rst_reg_wr", s_reg_wr, '0);
    check("rst_bvalid", s_bvalid, 1'b0);
    check("rst_rvalid", s_rvalid, 1'b0);
    check("rst_rdata", s_rdata, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {s_awready, s_wready, s_arready}, 3'b111);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);

    // Full-word writes to every register, then read back
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);

    // Partial strobe on reg1
    axi_write(4'h4, 32'h0000_0002, 4'hF, 0, 0, 0);
    axi_write(4'h4, 32'hAABB_CCDD, 4'b0010, 0, 0, 0);
    check("strb_merge", s_reg_o[63:32], 32'h0000_CC02);
    axi_read(4'h4, 0);

    // W leads AW by three cycles
    axi_write(4'h8, 32'h0000_0055, 4'hF, 3, 0, 0);
    check("w_first_reg2", s_reg_o[95:64], 32'h0000_0055);

    // BREADY stalled five cycles, then a second write
    axi_write(4'hC, 32'h1111_1111, 4'hF, 0, 0, 5);
    axi_write(4'h0, 32'h2222_2222, 4'hF, 0, 0, 0);
    axi_read(4'hC, 0);
    axi_read(4'h0, 2);

    // AR and write commit on the same edge to the same register
    old_val = model[1];
    s_araddr = 4'h5; s_awaddr = 4'h4; s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF;
    check("same_cyc_readies", {s_awready, s_wready, s_arready}, 3'b111);
    s_arvalid = 1'b1; s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(negedge clk);
    s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
    model_write(4'h4, 32'hDEAD_BEEF, 4'hF);
    check("same_cyc_old_rdata", s_rdata, old_val);
    check("same_cyc_rvalid_bvalid", {s_rvalid, s_bvalid}, 2'b11);
    check("same_cyc_reg_o", s_reg_o, model_flat());
    @(negedge clk);
    check("same_cyc_done", {s_rvalid, s_bvalid}, 2'b00);
    axi_read(4'h4, 0);

    // Randomized mix of reads and writes
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 1) == 0)
        axi_write(4'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2));
      else
        axi_read(4'($urandom), $urandom_range(0, 2));
    end

    // Reset while AW is held and W is about to arrive
    @(negedge clk);
    s_awaddr = 4'h4; s_awvalid = 1'b1;
    @(negedge clk);
    s_awvalid = 1'b0;
    check("aw_held_awready", s_awready, 1'b0);
    s_wdata = 32'hCAFE_F00D; s_wstrb = 4'hF; s_wvalid = 1'b1;
    #2;
    s_wvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) model[i] = '0;
    check("midrst_reg_o", s_reg_o, '0);
    check("midrst_bvalid", s_bvalid, 1'b0);
    check("midrst_reg_wr", s_reg_wr, '0);
    check("midrst_rvalid", s_rvalid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_readies", {s_awready, s_wready, s_arready}, 3'b111);
    // A lone W after reset must wait for a fresh address
    s_wdata = 32'h0BAD_F00D; s_wvalid = 1'b1;
    @(negedge clk);
    s_wvalid = 1'b0;
    repeat (3) begin
      check("no_commit_bvalid", s_bvalid, 1'b0);
      check("no_commit_reg_o", s_reg_o, '0);
      @(negedge clk);
    end
    s_awaddr = 4'h8; s_awvalid = 1'b1;
    @(negedge clk);
    s_awvalid = 1'b0;
    model_write(4'h8, 32'h0BAD_F00D, 4'hF);
    check("late_aw_bvalid", s_bvalid, 1'b1);
    check("late_aw_reg_o", s_reg_o, model_flat());
    @(negedge clk);
    check("late_aw_bclear", s_bvalid, 1'b0);
    axi_read(4'hA, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
